// File: rtl/packet_filter_pkg.sv
// Shared types and constants for the packet filter ingress path.
package packet_filter_pkg;

    localparam int MAC_BITS = 48;
    localparam logic [MAC_BITS-1:0] MAC_INVALID_MASK = 48'hC000_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } dest_state_e;

    typedef struct packed {
        logic [3:0] port;
        logic       invalid;
        logic       bcast;
    } dest_result_t;

endpackage

// File: rtl/dest_fifo.sv
// Small synchronous result FIFO; a push while full is taken only
// together with a pop in the same cycle.
module dest_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dest_resolver.sv
// Destination MAC to egress port resolver with result FIFO.
// Optional broadcast detection is enabled with DEST_BCAST_EN.
module dest_resolver
    import packet_filter_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAC_WORDS = 3,
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 2,
    localparam int PORT_W   = $clog2(NUM_PORTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tvalid,
    input  logic              in_tlast,
    output logic              in_tready,
    output logic [PORT_W-1:0] dest_tdata,
    output logic              dest_tuser,
    output logic              dest_bcast,
    output logic              dest_tvalid,
    input  logic              dest_tready,
    output logic [15:0]       err_cnt
);
    localparam int WCNT_W = $clog2(MAC_WORDS) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAC_WORDS - 1);
`ifdef DEST_BCAST_EN
    localparam int RES_W = PORT_W + 2;
`else
    localparam int RES_W = PORT_W + 1;
`endif

    dest_state_e         state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [MAC_BITS-1:0] mac_q, mac_d, mac_full;
    logic [15:0]         err_q, err_d;

    logic              done_beat, runt_beat, push_req, push, accept;
    logic              fifo_full, fifo_empty;
    logic [PORT_W-1:0] res_port;
    logic              res_inv;
    logic [RES_W-1:0]  push_data, head_data;
    dest_result_t      head;
`ifdef DEST_BCAST_EN
    logic              res_bcast;
`endif

    assign accept = in_tvalid && in_tready;
    assign push   = push_req && in_tready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            mac_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            mac_q   <= mac_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        mac_d   = mac_q;
        if (accept) begin
            unique case (state_q)
                IDLE, HDR: begin
                    if (runt_beat) begin
                        state_d = IDLE;
                        wcnt_d  = '0;
                        mac_d   = '0;
                    end else if (done_beat) begin
                        state_d = in_tlast ? IDLE : BODY;
                        wcnt_d  = '0;
                        mac_d   = mac_full;
                    end else begin
                        state_d = HDR;
                        wcnt_d  = wcnt_q + WCNT_W'(1);
                        mac_d   = mac_full;
                    end
                end
                BODY: if (in_tlast) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Word 0 starts a fresh MAC; later words shift in below it.
    always_comb begin
        done_beat = 1'b0;
        runt_beat = 1'b0;
        unique case (state_q)
            IDLE: begin
                done_beat = (MAC_WORDS == 1);
                runt_beat = in_tlast && (MAC_WORDS != 1);
            end
            HDR: begin
                done_beat = (wcnt_q == WCNT_LAST);
                runt_beat = in_tlast && (wcnt_q != WCNT_LAST);
            end
            default: ;
        endcase
        mac_full  = (state_q == IDLE) ? MAC_BITS'(in_tdata)
                                      : ((mac_q << DATA_W) | MAC_BITS'(in_tdata));
        push_req  = in_tvalid && (done_beat || runt_beat);
        in_tready = !(push_req && fifo_full && !dest_tready);

        res_port  = PORT_W'(mac_full);
        res_inv   = ((mac_full & MAC_INVALID_MASK) == MAC_INVALID_MASK)
                 || (32'(res_port) >= NUM_PORTS);
`ifdef DEST_BCAST_EN
        res_bcast = (mac_full == '1);
        if (res_bcast) begin
            res_port = '0;
            res_inv  = 1'b0;
        end
`endif
        if (runt_beat) begin
            res_port = '0;
            res_inv  = 1'b1;
`ifdef DEST_BCAST_EN
            res_bcast = 1'b0;
`endif
        end
`ifdef DEST_BCAST_EN
        push_data = {res_port, res_inv, res_bcast};
`else
        push_data = {res_port, res_inv};
`endif
    end

    always_comb begin
        err_d = err_q;
        if (push && res_inv && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    dest_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (dest_tready),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        head.port    = 4'(head_data[RES_W-1 -: PORT_W]);
        head.invalid = head_data[RES_W-1-PORT_W];
`ifdef DEST_BCAST_EN
        head.bcast   = head_data[0];
`else
        head.bcast   = 1'b0;
`endif
    end

    assign dest_tdata  = PORT_W'(head.port);
    assign dest_tuser  = head.invalid;
    assign dest_bcast  = head.bcast;
    assign dest_tvalid = !fifo_empty;
    assign err_cnt     = err_q;

endmodule
